param_counter_display: RTL and testbench
========================================

PARAM_COUNTER_DISPLAY -- requirements
Module: param_counter_display

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits (1..32).
REQ-002 Parameter MAX, default 2**WIDTH-1: terminal count; the counter range is 0..MAX.
REQ-003 Parameter DIGITS, default 8: number of multiplexed seven-segment digits.
REQ-004 Parameter REFRESH_DIV, default 100000: clock cycles each digit is held active (>=2).
REQ-005 Parameter DEB_CYCLES, default 16: debounce stability window in cycles; used only with DEBOUNCE_EN.
REQ-006 clk  input  1  single system clock; all state rising-edge triggered.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 uphdnl  input  1  direction: 1 = count up, 0 = count down; asynchronous, sampled directly.
REQ-009 step  input  1  asynchronous push-button request for one count step.
REQ-010 load  input  1  synchronous load strobe, clk domain.
REQ-011 load_val  input  WIDTH  value loaded when load=1.
REQ-012 count_out  output  WIDTH  registered current count.
REQ-013 tc  output  1  one-cycle pulse on every wrap event.
REQ-014 seg  output  7  active-low segments, seg[0]=a .. seg[6]=g.
REQ-015 anode  output  DIGITS  active-low digit enables, one-hot-low.

Function
REQ-016 step SHALL pass a 2-flop synchronizer; a rising edge of the synchronized level SHALL produce exactly one step event, however long step is held.
REQ-017 Latency: if step is sampled low at edge N-1 and high at edge N, count_out SHALL change at edge N+2 (without DEBOUNCE_EN).
REQ-018 On a step event with uphdnl=1: count<MAX -> count+1; count==MAX -> 0 and tc=1 for that cycle.
REQ-019 On a step event with uphdnl=0: count>0 -> count-1; count==0 -> MAX and tc=1 for that cycle.
REQ-020 load=1 SHALL set count to load_val at the next edge, with priority over a coincident step event; that step event SHALL be discarded; tc SHALL stay 0.
REQ-021 If load_val>MAX, count SHALL load MAX.
REQ-022 tc SHALL be registered, asserted in the same cycle count_out shows the wrapped value, and low otherwise.
REQ-023 The display scan SHALL use a prescaler counting 0..REFRESH_DIV-1; on terminal value, the active digit index SHALL advance i -> i+1, wrapping DIGITS-1 -> 0.
REQ-024 Digit i SHALL show the hex nibble count_out[4i+3:4i], zero-extended beyond WIDTH; digits 0-F use standard hex glyphs (b, d lowercase).
REQ-025 anode[i] SHALL be 0 only while digit i is active; seg and anode SHALL be registered and change on the same edge.
REQ-026 Only DIGITS digits are scanned; at most one anode SHALL be low in any cycle.

Reset
REQ-027 rst=0 SHALL asynchronously clear count_out to 0, tc to 0, synchronizer/edge/debounce state to 0, prescaler to 0, and digit index to 0.
REQ-028 During reset, anode SHALL be all ones and seg 7'b1111111; after release, digit 0 SHALL be enabled from the first edge.
REQ-029 A step held high across reset release SHALL NOT generate a step event until it goes low and high again.
REQ-030 Reset asserted mid-scan or mid-debounce SHALL abandon that operation with no step event.

Configuration
REQ-031 Macro PARAM_COUNTER_DEBOUNCE_EN: when defined, the synchronized step SHALL be filtered; the filtered level changes only after the raw level differs from it for DEB_CYCLES consecutive cycles, and edge detection SHALL use the filtered level.
REQ-032 With the macro defined, step-to-count latency SHALL be DEB_CYCLES+2 edges; pulses shorter than DEB_CYCLES cycles SHALL be ignored.
REQ-033 Without the macro, no filter logic SHALL be instantiated and REQ-017 latency applies; DEB_CYCLES is unused.

Verification (WIDTH=8, MAX=255, DIGITS=8, REFRESH_DIV=4, DEB_CYCLES=4)
REQ-034 rst=0 for 3 cycles, release; uphdnl=1, 3 step pulses held 10 cycles each -> count_out=3, tc never 1, each change exactly 2 edges after step sampled high.
REQ-035 load=1, load_val=254, then 2 up steps -> 255 then 0; tc=1 for exactly the cycle count_out becomes 0.
REQ-036 count=0, uphdnl=0, one step -> count_out=255, tc=1 for one cycle; load coincident with step event, load_val=0x5A -> count_out=0x5A, tc=0.
REQ-037 count=0xA7, run 40 cycles -> anode cycles FE,FD,FB,...,7F every 4 cycles; digit0 seg=7'b1111000 (7), digit1 seg=7'b0001000 (A), digits 2-7 seg=7'b1000000 (0).
REQ-038 With PARAM_COUNTER_DEBOUNCE_EN: 3-cycle step glitch -> no change; 8-cycle pulse -> count+1 at DEB_CYCLES+2=6 edges after first high sample.
REQ-039 step held high through rst release, then low 5, high 5 cycles -> exactly one step event; rst asserted 1 cycle after a step sample -> count 0, no later step event.

Source files
------------

// File: rtl/param_counter_display.sv
// Up/down counter stepped by a push-button, with a multiplexed hex seven-segment display.
// Define PARAM_COUNTER_DEBOUNCE_EN to add a stability filter on the synchronized step input.
module param_counter_display #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] MAX         = {WIDTH{1'b1}},
    parameter int               DIGITS      = 8,
    parameter int               REFRESH_DIV = 100000,
    parameter int               DEB_CYCLES  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uphdnl,
    input  logic              step,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  count_out,
    output logic              tc,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] anode
);

    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PAD_W = (4 * DIGITS > WIDTH) ? 4 * DIGITS : WIDTH;

    logic             step_meta_reg;
    logic             step_sync_reg;
    logic             step_prev_reg;
    logic             armed_reg;
    logic [1:0]       valid_reg;
    logic             step_level;
    logic             step_event;

    logic [WIDTH-1:0] count_reg;
    logic             tc_reg;
    logic [PRE_W-1:0] pre_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [6:0]       seg_reg;
    logic [DIGITS-1:0] anode_reg;
    logic [DIGITS-1:0] anode_next;
    logic [PAD_W-1:0] padded;
    logic [3:0]       nibble [DIGITS];

    // The synchronizer resets to 0, so a button held through reset would look like a
    // fresh press; armed_reg only opens once a real low sample has passed both flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_meta_reg <= 1'b0;
            step_sync_reg <= 1'b0;
            step_prev_reg <= 1'b0;
            armed_reg     <= 1'b0;
            valid_reg     <= 2'b00;
        end else begin
            step_meta_reg <= step;
            step_sync_reg <= step_meta_reg;
            valid_reg     <= {valid_reg[0], 1'b1};
            if (valid_reg[1] && !step_sync_reg)
                armed_reg <= 1'b1;
            step_prev_reg <= step_level;
        end
    end

`ifdef PARAM_COUNTER_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    logic             filt_reg;
    logic [DEB_W-1:0] deb_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_reg    <= 1'b0;
            deb_cnt_reg <= '0;
        end else if (step_sync_reg != filt_reg) begin
            if (deb_cnt_reg == DEB_W'(DEB_CYCLES - 1)) begin
                filt_reg    <= step_sync_reg;
                deb_cnt_reg <= '0;
            end else begin
                deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
            end
        end else begin
            deb_cnt_reg <= '0;
        end
    end

    assign step_level = filt_reg;
`else
    assign step_level = step_sync_reg;
`endif

    assign step_event = step_level & ~step_prev_reg & armed_reg;

    // Load wins over a coincident step; the step is simply dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
            tc_reg    <= 1'b0;
        end else begin
            tc_reg <= 1'b0;
            if (load) begin
                count_reg <= (load_val > MAX) ? MAX : load_val;
            end else if (step_event) begin
                if (uphdnl) begin
                    if (count_reg == MAX) begin
                        count_reg <= '0;
                        tc_reg    <= 1'b1;
                    end else begin
                        count_reg <= count_reg + WIDTH'(1);
                    end
                end else begin
                    if (count_reg == '0) begin
                        count_reg <= MAX;
                        tc_reg    <= 1'b1;
                    end else begin
                        count_reg <= count_reg - WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_reg <= '0;
            idx_reg <= '0;
        end else if (pre_reg == PRE_W'(REFRESH_DIV - 1)) begin
            pre_reg <= '0;
            idx_reg <= (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
        end else begin
            pre_reg <= pre_reg + PRE_W'(1);
        end
    end

    assign padded = PAD_W'(count_reg);

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nibble[gi]     = padded[4*gi +: 4];
            assign anode_next[gi] = (idx_reg != IDX_W'(gi));
        end
    endgenerate

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        case (nib)
            4'h0: hex_glyph = 7'b1000000;
            4'h1: hex_glyph = 7'b1111001;
            4'h2: hex_glyph = 7'b0100100;
            4'h3: hex_glyph = 7'b0110000;
            4'h4: hex_glyph = 7'b0011001;
            4'h5: hex_glyph = 7'b0010010;
            4'h6: hex_glyph = 7'b0000010;
            4'h7: hex_glyph = 7'b1111000;
            4'h8: hex_glyph = 7'b0000000;
            4'h9: hex_glyph = 7'b0010000;
            4'hA: hex_glyph = 7'b0001000;
            4'hB: hex_glyph = 7'b0000011;
            4'hC: hex_glyph = 7'b1000110;
            4'hD: hex_glyph = 7'b0100001;
            4'hE: hex_glyph = 7'b0000110;
            default: hex_glyph = 7'b0001110;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_reg   <= 7'b1111111;
            anode_reg <= '1;
        end else begin
            seg_reg   <= hex_glyph(nibble[idx_reg]);
            anode_reg <= anode_next;
        end
    end

    assign count_out = count_reg;
    assign tc        = tc_reg;
    assign seg       = seg_reg;
    assign anode     = anode_reg;

endmodule

// File: tb/tb_param_counter_display.sv
// Bench for param_counter_display: per-cycle comparison against a history-based model plus directed checks.
module tb_param_counter_display;

    localparam int WIDTH       = 8;
    localparam int DIGITS      = 8;
    localparam int REFRESH_DIV = 4;
    localparam int DEB_CYCLES  = 4;
    localparam logic [7:0] MAX = 8'd255;
`ifdef PARAM_COUNTER_DEBOUNCE_EN
    localparam int LAT    = DEB_CYCLES + 2;
    localparam int MINRUN = DEB_CYCLES;
`else
    localparam int LAT    = 2;
    localparam int MINRUN = 1;
`endif

    logic       clk;
    logic       rst;
    logic       uphdnl;
    logic       step;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] count_out;
    logic       tc;
    logic [6:0] seg;
    logic [7:0] anode;

    logic       load2;
    logic [3:0] load_val2;
    logic [3:0] count2;
    logic       tc2;
    logic [6:0] seg2;
    logic [1:0] anode2;

    int tests = 0;
    int fails = 0;

    param_counter_display #(
        .WIDTH(WIDTH), .MAX(MAX), .DIGITS(DIGITS),
        .REFRESH_DIV(REFRESH_DIV), .DEB_CYCLES(DEB_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .uphdnl(uphdnl), .step(step), .load(load),
        .load_val(load_val), .count_out(count_out), .tc(tc), .seg(seg), .anode(anode)
    );

    // Small instance with a non-power-of-two terminal count, used for saturation checks.
    param_counter_display #(
        .WIDTH(4), .MAX(4'd9), .DIGITS(2), .REFRESH_DIV(2), .DEB_CYCLES(DEB_CYCLES)
    ) dut2 (
        .clk(clk), .rst(rst), .uphdnl(uphdnl), .step(step), .load(load2),
        .load_val(load_val2), .count_out(count2), .tc(tc2), .seg(seg2), .anode(anode2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b1000000;  4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;  4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;  4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;  4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;  4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;  4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;  4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;  default: glyph = 7'b0001110;
        endcase
    endfunction

    // Model: raw step samples since reset release, indexed by edge number (1 = first edge).
    bit         hist [0:8191];
    int         ecnt;
    logic [7:0] m_count;
    logic       m_tc;
    logic [7:0] m_anode;
    logic [6:0] m_seg;

    // A press is a low sample followed by a run of at least MINRUN high samples,
    // both taken after release; it takes effect LAT edges after the first high sample.
    function automatic bit press_lands_at(input int e);
        int n;
        n = e - LAT;
        if (n < 2) return 1'b0;
        if (hist[n-1]) return 1'b0;
        for (int k = 0; k < MINRUN; k++)
            if (!hist[n+k]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [8:0] next_state(input logic [7:0] cnt, input bit ld,
                                              input logic [7:0] lv, input bit ev, input bit up);
        if (ld)            return {1'b0, (lv > MAX) ? MAX : lv};
        if (!ev)           return {1'b0, cnt};
        if (up)            return (cnt == MAX) ? {1'b1, 8'd0} : {1'b0, cnt + 8'd1};
        return (cnt == 8'd0) ? {1'b1, MAX} : {1'b0, cnt - 8'd1};
    endfunction

    function automatic logic [6:0] digit_glyph(input logic [7:0] cnt, input int d);
        logic [31:0] wide;
        wide = {24'd0, cnt} >> (4 * d);
        return glyph(wide[3:0]);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ecnt    <= 0;
            m_count <= 8'd0;
            m_tc    <= 1'b0;
            m_anode <= 8'hFF;
            m_seg   <= 7'h7F;
        end else begin
            {m_tc, m_count} <= next_state(m_count, load, load_val,
                                          press_lands_at(ecnt + 1), uphdnl);
            m_anode <= ~(8'd1 << ((ecnt / REFRESH_DIV) % DIGITS));
            m_seg   <= digit_glyph(m_count, (ecnt / REFRESH_DIV) % DIGITS);
            if (ecnt + 1 < 8192)
                hist[ecnt+1] <= step;
            ecnt <= ecnt + 1;
        end
    end

    always @(negedge clk) begin
        check("count_out", count_out, m_count);
        check("tc", tc, m_tc);
        check("anode", anode, m_anode);
        check("seg", seg, m_seg);
        check("anode_onehot", ($countones(~anode) <= 1), 1);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    logic [7:0] seen_anodes;

    initial begin
        rst = 1'b0; step = 1'b0; uphdnl = 1'b1; load = 1'b0; load_val = 8'd0;
        load2 = 1'b0; load_val2 = 4'd0;
        cyc(3);
        check("reset_count", count_out, 8'd0);
        check("reset_tc", tc, 1'b0);
        check("reset_anode", anode, 8'hFF);
        check("reset_seg", seg, 7'b1111111);
        rst = 1'b1;
        cyc(1);
        check("first_digit", anode, 8'hFE);
        $display("[TB] reset released, digit0 active");

        load2 = 1'b1; load_val2 = 4'd12;
        cyc(1);
        load2 = 1'b0;
        check("sat_load", count2, 4'd9);
        $display("[TB] small instance load 12 -> %0d", count2);
        cyc(3);

        step = 1'b1;
        cyc(LAT);
        check("latency_hold", count_out, 8'd0);
        cyc(1);
        check("latency_step", count_out, 8'd1);
        check("sat_wrap", count2, 4'd0);
        check("sat_wrap_tc", tc2, 1'b1);
        cyc(9 - LAT);
        step = 1'b0;
        cyc(10);
        for (int p = 0; p < 2; p++) begin
            step = 1'b1; cyc(10);
            step = 1'b0; cyc(10);
            $display("[TB] up step, count=%0d", count_out);
        end
        check("three_steps", count_out, 8'd3);

        load = 1'b1; load_val = 8'd254;
        cyc(1);
        load = 1'b0;
        check("load_254", count_out, 8'd254);
        step = 1'b1; cyc(LAT + 1);
        check("up_to_max", count_out, 8'd255);
        check("no_tc_at_max", tc, 1'b0);
        cyc(8 - LAT); step = 1'b0; cyc(10);
        step = 1'b1; cyc(LAT + 1);
        check("wrap_up", count_out, 8'd0);
        check("wrap_up_tc", tc, 1'b1);
        cyc(1);
        check("wrap_up_tc_end", tc, 1'b0);
        $display("[TB] wrap up done, count=%0d", count_out);
        cyc(8 - LAT); step = 1'b0; cyc(10);

        uphdnl = 1'b0;
        step = 1'b1; cyc(LAT + 1);
        check("wrap_down", count_out, 8'd255);
        check("wrap_down_tc", tc, 1'b1);
        cyc(9 - LAT); step = 1'b0; cyc(10);
        step = 1'b1; cyc(LAT);
        load = 1'b1; load_val = 8'h5A;
        cyc(1);
        load = 1'b0;
        check("load_priority", count_out, 8'h5A);
        check("load_no_tc", tc, 1'b0);
        cyc(9 - LAT); step = 1'b0; cyc(10);
        check("step_discarded", count_out, 8'h5A);
        $display("[TB] load over step, count=%0h", count_out);
        uphdnl = 1'b1;

        load = 1'b1; load_val = 8'hA7;
        cyc(1);
        load = 1'b0;
        cyc(2);
        seen_anodes = 8'h00;
        for (int c = 0; c < 40; c++) begin
            cyc(1);
            case (anode)
                8'hFE: check("seg_digit0", seg, 7'b1111000);
                8'hFD: check("seg_digit1", seg, 7'b0001000);
                default: check("seg_digit_hi", seg, 7'b1000000);
            endcase
            seen_anodes = seen_anodes | ~anode;
        end
        check("all_digits_scanned", seen_anodes, 8'hFF);
        $display("[TB] scan of 0xA7 done");

`ifdef PARAM_COUNTER_DEBOUNCE_EN
        step = 1'b1; cyc(3); step = 1'b0; cyc(12);
        check("glitch_ignored", count_out, 8'hA7);
        step = 1'b1; cyc(LAT);
        check("deb_hold", count_out, 8'hA7);
        cyc(1);
        check("deb_step", count_out, 8'hA8);
        cyc(7 - LAT); step = 1'b0; cyc(12);
        $display("[TB] debounce checks done, count=%0h", count_out);
`endif

        step = 1'b1; rst = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(8);
        check("held_through_reset", count_out, 8'd0);
        step = 1'b0; cyc(5);
        step = 1'b1; cyc(5);
        step = 1'b0; cyc(12);
        check("one_event_after_release", count_out, 8'd1);
        $display("[TB] held-through-reset press, count=%0d", count_out);

        step = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        cyc(10);
        step = 1'b0;
        cyc(12);
        check("abandoned_step", count_out, 8'd0);
        $display("[TB] reset during press, count=%0d", count_out);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
